// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter: widths, the
// "no pending producer" status value and the per-port bypass resolver.
package regfile_read_arbiter_pkg;

  localparam int N_REQ  = 3;   // 0 = issue, 1 = load/store buffer, 2 = branch
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int PTR_W  = 2;   // enough to index N_REQ requesters

  localparam logic [DATA_W-1:0] NO_TAG = 32'd1000;

  typedef struct packed {
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] data;
  } rd_result_t;

  // Resolve one read port: x0 is hard-wired, and a same-cycle commit of the
  // producer the register file still reports as pending overrides the read.
  function automatic rd_result_t resolve_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rf_status,
    input logic [DATA_W-1:0] rf_data,
    input logic              cm_we,
    input logic [ADDR_W-1:0] cm_addr,
    input logic [DATA_W-1:0] cm_data,
    input logic [DATA_W-1:0] cm_tag
  );
    rd_result_t res;
    res.status = rf_status;
    res.data   = rf_data;
    if (addr == {ADDR_W{1'b0}}) begin
      res.status = NO_TAG;
      res.data   = {DATA_W{1'b0}};
    end else if (cm_we && (cm_addr == addr) && (rf_status == cm_tag)) begin
      res.status = NO_TAG;
      res.data   = cm_data;
    end else begin
      res.status = rf_status;
      res.data   = rf_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// Generic N-way round-robin arbiter: picks the first set request at or
// after ptr (wrapping), reporting it one-hot and as an encoded index.
module rr_arbiter_n #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Rotating priority search starting at the pointer slot.
  always_comb begin
    grant = {N{1'b0}};
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file's two read ports among the requesters: one
// round-robin grant per cycle, commit bypass on each port, and a registered
// per-requester response one cycle after the grant.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr1,
  input  logic [N_REQ*ADDR_W-1:0] req_addr2,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rf_en_1,
  output logic                    rf_en_2,
  output logic [ADDR_W-1:0]       rf_addr_1,
  output logic [ADDR_W-1:0]       rf_addr_2,
  input  logic [DATA_W-1:0]       rf_status_1,
  input  logic [DATA_W-1:0]       rf_status_2,
  input  logic [DATA_W-1:0]       rf_data_1,
  input  logic [DATA_W-1:0]       rf_data_2,
  input  logic                    cm_we,
  input  logic [ADDR_W-1:0]       cm_addr,
  input  logic [DATA_W-1:0]       cm_data,
  input  logic [DATA_W-1:0]       cm_tag,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_status1,
  output logic [DATA_W-1:0]       rsp_status2,
  output logic [DATA_W-1:0]       rsp_data1,
  output logic [DATA_W-1:0]       rsp_data2
);

  logic [PTR_W-1:0]  rr_ptr_r;
  logic [N_REQ-1:0]  arb_grant_s;
  logic [PTR_W-1:0]  arb_idx_s;
  logic              arb_any_s;
  logic              grant_ok_s;
  logic [N_REQ-1:0]  grant_s;
  logic [ADDR_W-1:0] addr1_s;
  logic [ADDR_W-1:0] addr2_s;
  rd_result_t        rd1_s;
  rd_result_t        rd2_s;
  logic [N_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0] rsp_status1_r;
  logic [DATA_W-1:0] rsp_status2_r;
  logic [DATA_W-1:0] rsp_data1_r;
  logic [DATA_W-1:0] rsp_data2_r;

  rr_arbiter_n #(
    .N     (N_REQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // Qualify the arbiter result with stall/flush and steer the winner's addresses.
  always_comb begin
    grant_ok_s = rdy_in & ~clear & arb_any_s;
    grant_s    = {N_REQ{1'b0}};
    addr1_s    = {ADDR_W{1'b0}};
    addr2_s    = {ADDR_W{1'b0}};
    if (grant_ok_s) begin
      grant_s = arb_grant_s;
      addr1_s = req_addr1[int'(arb_idx_s)*ADDR_W +: ADDR_W];
      addr2_s = req_addr2[int'(arb_idx_s)*ADDR_W +: ADDR_W];
    end else begin
      grant_s = {N_REQ{1'b0}};
    end
  end

  // Patch both read ports with x0 forcing and the same-cycle commit bypass.
  always_comb begin
    rd1_s = resolve_read(addr1_s, rf_status_1, rf_data_1, cm_we, cm_addr, cm_data, cm_tag);
    rd2_s = resolve_read(addr2_s, rf_status_2, rf_data_2, cm_we, cm_addr, cm_data, cm_tag);
  end

  assign req_ready = grant_s;
  assign rf_en_1   = grant_ok_s;
  assign rf_en_2   = grant_ok_s;
  assign rf_addr_1 = addr1_s;
  assign rf_addr_2 = addr2_s;

  // Response register and round-robin pointer; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_r      <= {PTR_W{1'b0}};
      rsp_valid_r   <= {N_REQ{1'b0}};
      rsp_status1_r <= NO_TAG;
      rsp_status2_r <= NO_TAG;
      rsp_data1_r   <= {DATA_W{1'b0}};
      rsp_data2_r   <= {DATA_W{1'b0}};
    end else if (rdy_in) begin
      if (clear) begin
        rsp_valid_r <= {N_REQ{1'b0}};
      end else begin
        rsp_valid_r <= grant_s;
      end
      if (grant_ok_s) begin
        rsp_status1_r <= rd1_s.status;
        rsp_data1_r   <= rd1_s.data;
        rsp_status2_r <= rd2_s.status;
        rsp_data2_r   <= rd2_s.data;
        if (arb_idx_s == PTR_W'(N_REQ - 1)) begin
          rr_ptr_r <= {PTR_W{1'b0}};
        end else begin
          rr_ptr_r <= arb_idx_s + PTR_W'(1);
        end
      end
    end
  end

  assign rsp_valid   = rsp_valid_r;
  assign rsp_status1 = rsp_status1_r;
  assign rsp_status2 = rsp_status2_r;
  assign rsp_data1   = rsp_data1_r;
  assign rsp_data2   = rsp_data2_r;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed reset, round-robin,
// stall and flush sequences, a vector table of single-requester reads, and a
// randomized run against a behavioural reference model.
module tb_regfile_read_arbiter;
  import regfile_read_arbiter_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in, rdy_in, clear;
  logic [N_REQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr1, req_addr2;
  logic                    rf_en_1, rf_en_2;
  logic [ADDR_W-1:0]       rf_addr_1, rf_addr_2, cm_addr;
  logic [DATA_W-1:0]       rf_status_1, rf_status_2, rf_data_1, rf_data_2;
  logic                    cm_we;
  logic [DATA_W-1:0]       cm_data, cm_tag;
  logic [DATA_W-1:0]       rsp_status1, rsp_status2, rsp_data1, rsp_data2;

  // Bench-side register file: either fixed values or a memory indexed by the read address
  logic              use_mem;
  logic [DATA_W-1:0] tb_s1, tb_d1, tb_s2, tb_d2;
  logic [DATA_W-1:0] mem_stat [32];
  logic [DATA_W-1:0] mem_data [32];

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  always_comb begin
    if (use_mem) begin
      rf_status_1 = mem_stat[rf_addr_1];
      rf_data_1   = mem_data[rf_addr_1];
      rf_status_2 = mem_stat[rf_addr_2];
      rf_data_2   = mem_data[rf_addr_2];
    end else begin
      rf_status_1 = tb_s1;
      rf_data_1   = tb_d1;
      rf_status_2 = tb_s2;
      rf_data_2   = tb_d2;
    end
  end

  regfile_read_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_valid(req_valid), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_ready(req_ready), .rf_en_1(rf_en_1), .rf_en_2(rf_en_2),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_status_1(rf_status_1), .rf_status_2(rf_status_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .cm_we(cm_we), .cm_addr(cm_addr), .cm_data(cm_data), .cm_tag(cm_tag),
    .rsp_valid(rsp_valid), .rsp_status1(rsp_status1), .rsp_status2(rsp_status2),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference read: x0 reads as ready/zero; a commit to the register whose
  // pending tag matches makes the value ready with the committed data.
  task automatic ref_read(input logic [4:0] a, input logic [31:0] st, input logic [31:0] dt,
                          output logic [31:0] ost, output logic [31:0] odt);
    if (a == 5'd0) begin
      ost = 32'd1000; odt = 32'd0;
    end else if (cm_we && cm_addr == a && st == cm_tag) begin
      ost = 32'd1000; odt = cm_data;
    end else begin
      ost = st; odt = dt;
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a1, a2;
    logic [31:0] s1, d1, s2, d2;
    logic        cwe;
    logic [4:0]  caddr;
    logic [31:0] cdata, ctag;
    logic [31:0] e_s1, e_d1, e_s2, e_d2;
  } vec_t;

  vec_t vt [9];

  task automatic load_vec(input vec_t v);
    req_valid = v.valid;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr1[i*ADDR_W +: ADDR_W] = v.valid[i] ? v.a1 : 5'd30;
      req_addr2[i*ADDR_W +: ADDR_W] = v.valid[i] ? v.a2 : 5'd30;
    end
    tb_s1 = v.s1; tb_d1 = v.d1; tb_s2 = v.s2; tb_d2 = v.d2;
    cm_we = v.cwe; cm_addr = v.caddr; cm_data = v.cdata; cm_tag = v.ctag;
  endtask

  // Randomized-phase model state
  int          m_ptr;
  logic [2:0]  m_valid;
  logic [31:0] m_s1, m_d1, m_s2, m_d2;
  logic [4:0]  ra1 [3];
  logic [4:0]  ra2 [3];

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; use_mem = 1'b0;
    req_valid = '0; req_addr1 = '0; req_addr2 = '0;
    tb_s1 = 32'd0; tb_d1 = 32'd0; tb_s2 = 32'd0; tb_d2 = 32'd0;
    cm_we = 1'b0; cm_addr = '0; cm_data = '0; cm_tag = '0;
    for (int i = 0; i < 32; i++) begin
      mem_stat[i] = 32'd1000; mem_data[i] = 32'd0;
    end

    vt[0] = '{3'b010, 5'd5, 5'd7, 32'd1000, 32'h1234, 32'd3, 32'h0, 1'b0, 5'd0, 32'h0, 32'd0,
              32'd1000, 32'h1234, 32'd3, 32'h0};
    vt[1] = '{3'b001, 5'd3, 5'd7, 32'd1000, 32'h11, 32'd4, 32'h22, 1'b1, 5'd7, 32'hBEEF, 32'd4,
              32'd1000, 32'h11, 32'd1000, 32'hBEEF};
    vt[2] = '{3'b001, 5'd3, 5'd7, 32'd1000, 32'h11, 32'd4, 32'h22, 1'b1, 5'd7, 32'hBEEF, 32'd9,
              32'd1000, 32'h11, 32'd4, 32'h22};
    vt[3] = '{3'b100, 5'd0, 5'd6, 32'd2, 32'h55, 32'd8, 32'h66, 1'b0, 5'd0, 32'h0, 32'd0,
              32'd1000, 32'h0, 32'd8, 32'h66};
    vt[4] = '{3'b010, 5'd9, 5'd9, 32'd5, 32'h77, 32'd5, 32'h77, 1'b0, 5'd9, 32'h1, 32'd5,
              32'd5, 32'h77, 32'd5, 32'h77};
    vt[5] = '{3'b100, 5'd12, 5'd12, 32'd6, 32'hA, 32'd6, 32'hB, 1'b1, 5'd12, 32'hCAFE, 32'd6,
              32'd1000, 32'hCAFE, 32'd1000, 32'hCAFE};
    vt[6] = '{3'b001, 5'd12, 5'd11, 32'd6, 32'hA, 32'd6, 32'hB, 1'b1, 5'd13, 32'hCAFE, 32'd6,
              32'd6, 32'hA, 32'd6, 32'hB};
    // no request: payload must hold the previous response
    vt[7] = '{3'b000, 5'd4, 5'd4, 32'd1, 32'h9, 32'd1, 32'h9, 1'b0, 5'd0, 32'h0, 32'd0,
              32'd6, 32'hA, 32'd6, 32'hB};
    vt[8] = '{3'b010, 5'd0, 5'd0, 32'd3, 32'h44, 32'd3, 32'h44, 1'b1, 5'd0, 32'hDEAD, 32'd3,
              32'd1000, 32'h0, 32'd1000, 32'h0};

    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b1;

    // Reset mid-cycle: a live response must vanish without a clock edge
    @(negedge clk_in);
    load_vec(vt[0]);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_status1", rsp_status1, 32'd1000);
    chk("reset_data1", rsp_data1, 32'd0);
    chk("reset_status2", rsp_status2, 32'd1000);
    chk("reset_data2", rsp_data2, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Round-robin with all three requesting; first grant proves pointer reset to 0
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(3'b001 << (i % 3)));
      @(negedge clk_in);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(3'b001 << (i % 3)));
    end

    // Stall: no grants, response valid frozen
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_rf_en", 32'(rf_en_1), 32'd0);
      @(negedge clk_in);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'(3'b100));
    end
    rdy_in = 1'b1;
    #1 chk("post_stall_ready", 32'(req_ready), 32'(3'b001));
    @(negedge clk_in);
    chk("post_stall_rsp", 32'(rsp_valid), 32'(3'b001));

    // Flush right after a grant
    clear = 1'b1;
    #1 chk("clear_ready", 32'(req_ready), 32'd0);
    @(negedge clk_in);
    chk("clear_rsp_valid", 32'(rsp_valid), 32'd0);
    clear = 1'b0;
    #1 chk("post_clear_ready", 32'(req_ready), 32'(3'b010));
    @(negedge clk_in);
    chk("post_clear_rsp", 32'(rsp_valid), 32'(3'b010));

    // Vector table of single-requester reads
    for (int i = 0; i < 9; i++) begin
      load_vec(vt[i]);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vt[i].valid));
      chk($sformatf("vec%0d_rf_en", i), 32'(rf_en_2), 32'(vt[i].valid != 3'b000));
      chk($sformatf("vec%0d_rf_addr1", i), 32'(rf_addr_1),
          (vt[i].valid != 3'b000) ? 32'(vt[i].a1) : 32'd0);
      chk($sformatf("vec%0d_rf_addr2", i), 32'(rf_addr_2),
          (vt[i].valid != 3'b000) ? 32'(vt[i].a2) : 32'd0);
      @(negedge clk_in);
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_status1", i), rsp_status1, vt[i].e_s1);
      chk($sformatf("vec%0d_data1", i), rsp_data1, vt[i].e_d1);
      chk($sformatf("vec%0d_status2", i), rsp_status2, vt[i].e_s2);
      chk($sformatf("vec%0d_data2", i), rsp_data2, vt[i].e_d2);
    end

    // Randomized run against the reference model, starting from a fresh reset
    req_valid = '0; cm_we = 1'b0;
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    use_mem = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem_stat[i] = 32'($urandom_range(0, 7));
      mem_data[i] = $urandom;
    end
    m_ptr = 0; m_valid = 3'b000;
    m_s1 = 32'd1000; m_d1 = 32'd0; m_s2 = 32'd1000; m_d2 = 32'd0;
    @(negedge clk_in);
    for (int c = 0; c < 300; c++) begin
      int win;
      logic [2:0] gvec;
      logic [31:0] s1, d1, s2, d2;
      rdy_in    = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 9) == 0);
      req_valid = 3'($urandom);
      for (int r = 0; r < N_REQ; r++) begin
        ra1[r] = 5'($urandom_range(0, 7));
        ra2[r] = 5'($urandom_range(0, 7));
        req_addr1[r*ADDR_W +: ADDR_W] = ra1[r];
        req_addr2[r*ADDR_W +: ADDR_W] = ra2[r];
      end
      cm_we   = 1'($urandom);
      cm_addr = 5'($urandom_range(0, 7));
      cm_tag  = 32'($urandom_range(0, 7));
      cm_data = $urandom;
      mem_stat[$urandom_range(0, 7)] = ($urandom_range(0, 8) == 8) ? 32'd1000 : 32'($urandom_range(0, 7));
      mem_data[$urandom_range(0, 7)] = $urandom;
      #1;
      win = -1;
      if (rdy_in && !clear) begin
        for (int k = 0; k < N_REQ; k++) begin
          int j;
          j = (m_ptr + k) % N_REQ;
          if (win < 0 && req_valid[j]) win = j;
        end
      end
      gvec = (win >= 0) ? 3'(1 << win) : 3'b000;
      chk("rnd_ready", 32'(req_ready), 32'(gvec));
      chk("rnd_rf_addr1", 32'(rf_addr_1), (win >= 0) ? 32'(ra1[win]) : 32'd0);
      if (rdy_in) begin
        m_valid = gvec;
        if (win >= 0) begin
          ref_read(ra1[win], mem_stat[ra1[win]], mem_data[ra1[win]], s1, d1);
          ref_read(ra2[win], mem_stat[ra2[win]], mem_data[ra2[win]], s2, d2);
          m_s1 = s1; m_d1 = d1; m_s2 = s2; m_d2 = d2;
          m_ptr = (win + 1) % N_REQ;
        end
      end
      @(negedge clk_in);
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rnd_status1", rsp_status1, m_s1);
      chk("rnd_data1", rsp_data1, m_d1);
      chk("rnd_status2", rsp_status2, m_s2);
      chk("rnd_data2", rsp_data2, m_d2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
